// File: rtl/pe_pkg.sv
// Shared types and width helpers for the PE spike-accumulation stage.
package pe_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        FIRE  = 1'b1
    } acc_state_t;

    // Counter / index width; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned acc_w(input int unsigned psum_w, input int unsigned num_psum);
        return psum_w + $clog2(num_psum) + 1;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/membrane_mem.sv
// Membrane potential store: one combinational read port, one write port,
// synchronous clear-all and asynchronous reset.
module membrane_mem
    import pe_pkg::*;
#(
    parameter int unsigned NUM_OUT   = 4,
    parameter int unsigned POT_WIDTH = 12,
    localparam int unsigned IW       = cnt_w(NUM_OUT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IW-1:0]        rd_addr,
    output logic [POT_WIDTH-1:0] rd_data,
    input  logic                 wr_en,
    input  logic [IW-1:0]        wr_addr,
    input  logic [POT_WIDTH-1:0] wr_data,
    input  logic                 clr
);

    logic [POT_WIDTH-1:0] mem [NUM_OUT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_OUT; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            for (int unsigned i = 0; i < NUM_OUT; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/spike_accumulator.sv
// Collects NUM_PSUM partial sums per neuron, integrates them into the membrane
// potential and fires with subtract-on-fire; potentials clear every NUM_TS timesteps.
module spike_accumulator
    import pe_pkg::*;
#(
    parameter int unsigned PSUM_WIDTH = 8,
    parameter int unsigned POT_WIDTH  = 12,
    parameter int unsigned NUM_PSUM   = 3,
    parameter int unsigned NUM_OUT    = 4,
    parameter int unsigned NUM_TS     = 2,
    parameter int unsigned THRESHOLD  = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [PSUM_WIDTH-1:0]       in_psum,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_spike,
    output logic [cnt_w(NUM_OUT)-1:0]   out_idx,
    output logic                        ts_done,
    output logic                        all_done
);

    localparam int unsigned IW = cnt_w(NUM_OUT);
    localparam int unsigned PW = cnt_w(NUM_PSUM);
    localparam int unsigned TW = cnt_w(NUM_TS);
    localparam int unsigned AW = acc_w(PSUM_WIDTH, NUM_PSUM);
    // Sum is widened past POT_WIDTH+1 when acc is wider, so saturation still
    // sees the true total for small POT_WIDTH configurations.
    localparam int unsigned SW = max_u(AW, POT_WIDTH) + 1;

    localparam logic [POT_WIDTH-1:0] POT_MAX = '1;
    localparam logic [POT_WIDTH-1:0] THR     = POT_WIDTH'(THRESHOLD);

    acc_state_t state, state_nxt;

    logic [AW-1:0]        acc;
    logic [PW-1:0]        psum_cnt;
    logic [IW-1:0]        neu_cnt;
    logic [TW-1:0]        ts_cnt;

    logic                 beat, last_beat, take, last_neu, last_ts;
    logic [SW-1:0]        pot_sum;
    logic [POT_WIDTH-1:0] pot, mem_rd, mem_wr;
    logic                 fire;

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == FIRE);

    assign beat      = in_valid && (state == ACCUM);
    assign last_beat = beat && (psum_cnt == PW'(NUM_PSUM - 1));
    assign take      = (state == FIRE) && out_ready;
    assign last_neu  = (neu_cnt == IW'(NUM_OUT - 1));
    assign last_ts   = (ts_cnt == TW'(NUM_TS - 1));

    always_comb begin
        pot_sum = SW'(mem_rd) + SW'(acc) + SW'(in_psum);
        pot     = (pot_sum > SW'(POT_MAX)) ? POT_MAX : pot_sum[POT_WIDTH-1:0];
        fire    = (pot >= THR);
        mem_wr  = fire ? (pot - THR) : pot;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (last_beat) state_nxt = FIRE;
            FIRE:    if (out_ready) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            psum_cnt  <= '0;
            neu_cnt   <= '0;
            ts_cnt    <= '0;
            out_spike <= 1'b0;
            out_idx   <= '0;
            ts_done   <= 1'b0;
            all_done  <= 1'b0;
        end else begin
            ts_done  <= 1'b0;
            all_done <= 1'b0;
            if (beat) begin
                acc      <= acc + AW'(in_psum);
                psum_cnt <= psum_cnt + 1'b1;
            end
            if (last_beat) begin
                out_spike <= fire;
                out_idx   <= neu_cnt;
            end
            if (take) begin
                acc      <= '0;
                psum_cnt <= '0;
                if (last_neu) begin
                    neu_cnt <= '0;
                    ts_done <= 1'b1;
                    if (last_ts) begin
                        ts_cnt   <= '0;
                        all_done <= 1'b1;
                    end else begin
                        ts_cnt <= ts_cnt + 1'b1;
                    end
                end else begin
                    neu_cnt <= neu_cnt + 1'b1;
                end
            end
        end
    end

    membrane_mem #(
        .NUM_OUT   (NUM_OUT),
        .POT_WIDTH (POT_WIDTH)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_addr (neu_cnt),
        .rd_data (mem_rd),
        .wr_en   (last_beat),
        .wr_addr (neu_cnt),
        .wr_data (mem_wr),
        .clr     (take && last_neu && last_ts)
    );

endmodule

// File: tb/tb_spike_accumulator.sv
// Self-checking bench for spike_accumulator: directed vector table, randomized
// traffic against a behavioural model, reset and saturation corner cases.
module tb_spike_accumulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_psum = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_spike;
    logic [1:0] out_idx;
    logic       ts_done;
    logic       all_done;

    logic       s_in_valid = 1'b0;
    logic       s_in_ready;
    logic [7:0] s_in_psum = '0;
    logic       s_out_valid;
    logic       s_out_ready = 1'b1;
    logic       s_out_spike;
    logic [1:0] s_out_idx;
    logic       s_ts_done;
    logic       s_all_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spike_accumulator #(
        .PSUM_WIDTH (8),
        .POT_WIDTH  (12),
        .NUM_PSUM   (3),
        .NUM_OUT    (4),
        .NUM_TS     (2),
        .THRESHOLD  (64)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_psum   (in_psum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_spike (out_spike),
        .out_idx   (out_idx),
        .ts_done   (ts_done),
        .all_done  (all_done)
    );

    spike_accumulator #(
        .PSUM_WIDTH (8),
        .POT_WIDTH  (8),
        .NUM_PSUM   (3),
        .NUM_OUT    (4),
        .NUM_TS     (2),
        .THRESHOLD  (255)
    ) dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_psum   (s_in_psum),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_spike (s_out_spike),
        .out_idx   (s_out_idx),
        .ts_done   (s_ts_done),
        .all_done  (s_all_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Behavioural model: potentials per neuron, current neuron and timestep.
    int m_mem[4];
    int m_neu;
    int m_ts;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_mem[i] = 0;
        m_neu = 0;
        m_ts  = 0;
    endtask

    task automatic model_step(input int sum, output bit sp, output int idx,
                              output bit td, output bit ad);
        int pot;
        pot = m_mem[m_neu] + sum;
        if (pot > 4095) pot = 4095;
        sp  = (pot >= 64);
        m_mem[m_neu] = sp ? pot - 64 : pot;
        idx = m_neu;
        td  = 0;
        ad  = 0;
        m_neu++;
        if (m_neu == 4) begin
            m_neu = 0;
            td = 1;
            m_ts++;
            if (m_ts == 2) begin
                m_ts = 0;
                ad = 1;
                for (int i = 0; i < 4; i++) m_mem[i] = 0;
            end
        end
    endtask

    // One neuron: three beats (optional idle gaps with junk data), result check,
    // optional backpressure hold, then handshake and pulse checks.
    task automatic run_neuron(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                              input bit esp, input int eidx, input bit etd, input bit ead,
                              input int gap, input int hold);
        logic [7:0] ps[3];
        ps[0] = a; ps[1] = b; ps[2] = c;
        out_ready = (hold == 0);
        for (int i = 0; i < 3; i++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                in_psum  = 8'($urandom);
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_psum  = ps[i];
            @(posedge clk); #1;
            if (i == 0) begin
                chk("ts_done_single_cycle", ts_done, 0);
                chk("all_done_single_cycle", all_done, 0);
            end
        end
        in_valid = 1'b0;
        in_psum  = 8'($urandom);
        chk("latency_out_valid", out_valid, 1);
        chk("fire_in_ready", in_ready, 0);
        chk("out_spike", out_spike, esp);
        chk("out_idx", out_idx, eidx);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_psum  = 8'($urandom);
            @(posedge clk); #1;
            chk("hold_out_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_out_spike", out_spike, esp);
            chk("hold_out_idx", out_idx, eidx);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_accept_out_valid", out_valid, 0);
        chk("post_accept_in_ready", in_ready, 1);
        chk("ts_done", ts_done, etd);
        chk("all_done", all_done, ead);
    endtask

    task automatic s_neuron(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                            input bit esp, input int eidx);
        logic [7:0] ps[3];
        ps[0] = a; ps[1] = b; ps[2] = c;
        for (int i = 0; i < 3; i++) begin
            s_in_valid = 1'b1;
            s_in_psum  = ps[i];
            @(posedge clk); #1;
        end
        s_in_valid = 1'b0;
        chk("sat_out_valid", s_out_valid, 1);
        chk("sat_out_spike", s_out_spike, esp);
        chk("sat_out_idx", s_out_idx, eidx);
        @(posedge clk); #1;
        chk("sat_in_ready", s_in_ready, 1);
    endtask

    typedef struct {
        logic [7:0] a, b, c;
        bit         sp;
        int         idx;
        bit         td, ad;
        int         gap, hold;
    } vec_t;

    vec_t tbl[24];

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit sp, td, ad;
        int idx;
        logic [7:0] r[3];

        tbl[0]  = '{8'd10, 8'd20, 8'd30, 1'b0, 0, 1'b0, 1'b0, 0, 0};
        tbl[1]  = '{8'd0,  8'd0,  8'd0,  1'b0, 1, 1'b0, 1'b0, 0, 0};
        tbl[2]  = '{8'd0,  8'd0,  8'd0,  1'b0, 2, 1'b0, 1'b0, 1, 0};
        tbl[3]  = '{8'd0,  8'd0,  8'd0,  1'b0, 3, 1'b1, 1'b0, 0, 0};
        tbl[4]  = '{8'd1,  8'd2,  8'd3,  1'b1, 0, 1'b0, 1'b0, 0, 0};
        tbl[5]  = '{8'd0,  8'd0,  8'd0,  1'b0, 1, 1'b0, 1'b0, 0, 5};
        tbl[6]  = '{8'd64, 8'd0,  8'd0,  1'b1, 2, 1'b0, 1'b0, 0, 0};
        tbl[7]  = '{8'd0,  8'd0,  8'd63, 1'b0, 3, 1'b1, 1'b1, 0, 0};
        tbl[8]  = '{8'd31, 8'd31, 8'd0,  1'b0, 0, 1'b0, 1'b0, 0, 0};
        tbl[9]  = '{8'd0,  8'd0,  8'd0,  1'b0, 1, 1'b0, 1'b0, 0, 0};
        tbl[10] = '{8'd0,  8'd0,  8'd0,  1'b0, 2, 1'b0, 1'b0, 0, 0};
        tbl[11] = '{8'd0,  8'd0,  8'd0,  1'b0, 3, 1'b1, 1'b0, 0, 0};
        tbl[12] = '{8'd2,  8'd0,  8'd0,  1'b1, 0, 1'b0, 1'b0, 0, 0};
        tbl[13] = '{8'd0,  8'd0,  8'd0,  1'b0, 1, 1'b0, 1'b0, 0, 0};
        tbl[14] = '{8'd0,  8'd0,  8'd0,  1'b0, 2, 1'b0, 1'b0, 0, 0};
        tbl[15] = '{8'd0,  8'd0,  8'd0,  1'b0, 3, 1'b1, 1'b1, 0, 0};
        for (int i = 0; i < 8; i++) begin
            tbl[16 + i] = '{8'd0, 8'd0, 8'd0, 1'b0, i % 4, (i % 4) == 3, i == 7, 0, 0};
        end

        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_spike", out_spike, 0);
        chk("reset_out_idx", out_idx, 0);
        chk("reset_ts_done", ts_done, 0);
        chk("reset_all_done", all_done, 0);
        chk("reset_sat_out_valid", s_out_valid, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 24; i++) begin
            run_neuron(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].sp, tbl[i].idx,
                       tbl[i].td, tbl[i].ad, tbl[i].gap, tbl[i].hold);
        end
        model_reset();

        for (int n = 0; n < 48; n++) begin
            for (int k = 0; k < 3; k++) begin
                r[k] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 40));
            end
            model_step(int'(r[0]) + int'(r[1]) + int'(r[2]), sp, idx, td, ad);
            run_neuron(r[0], r[1], r[2], sp, idx, td, ad,
                       $urandom_range(0, 1), $urandom_range(0, 2));
        end

        // Reach neuron 2, feed two beats, then reset asynchronously mid-cycle.
        for (int n = 0; n < 4 && m_neu != 2; n++) begin
            model_step(90, sp, idx, td, ad);
            run_neuron(8'd30, 8'd30, 8'd30, sp, idx, td, ad, 0, 0);
        end
        chk("reached_neuron2", out_idx, 1);
        in_valid = 1'b1;
        in_psum  = 8'd50;
        repeat (2) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_spike", out_spike, 0);
        chk("midrst_out_idx", out_idx, 0);
        chk("midrst_ts_done", ts_done, 0);
        chk("midrst_all_done", all_done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        run_neuron(8'd0, 8'd0, 8'd0, 1'b0, 0, 1'b0, 1'b0, 0, 0);
        model_step(0, sp, idx, td, ad);
        model_step(60, sp, idx, td, ad);
        run_neuron(8'd20, 8'd20, 8'd20, sp, idx, td, ad, 0, 0);

        // Saturating configuration: 765 clamps to 255, fires, leaves 0 behind.
        s_neuron(8'd255, 8'd255, 8'd255, 1'b1, 0);
        s_neuron(8'd0, 8'd0, 8'd0, 1'b0, 1);
        s_neuron(8'd0, 8'd0, 8'd0, 1'b0, 2);
        s_neuron(8'd0, 8'd0, 8'd0, 1'b0, 3);
        s_neuron(8'd0, 8'd0, 8'd0, 1'b0, 0);
        s_neuron(8'd200, 8'd54, 8'd0, 1'b0, 1);
        s_neuron(8'd0, 8'd0, 8'd0, 1'b0, 2);
        s_neuron(8'd0, 8'd0, 8'd0, 1'b0, 3);
        chk("sat_all_done", s_all_done, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
